// File: rtl/systolic_row_drain.sv
// Drain controller for one systolic-array row: shifts PE accumulators out of the
// leftmost PE, converts sign-magnitude to two's complement and streams them via a FIFO.
module systolic_row_drain #(
  parameter int DATA_WIDTH_BITS = 16,
  parameter int INT_BITS        = 7,
  parameter int FRAC_BITS       = 8,
  parameter int N_PE            = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       drain_start,
  output logic                       drain_busy,
  output logic                       drain_done,
  output logic                       shift_out,
  output logic                       rst_output,
  input  logic [DATA_WIDTH_BITS-1:0] acc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH_BITS-1:0] out_data,
  output logic                       out_last
);

  localparam int DW    = DATA_WIDTH_BITS;
  localparam int MAG_W = INT_BITS + FRAC_BITS;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = (N_PE > 1) ? $clog2(N_PE + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CLEAR, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fcount;
  logic          push;
  logic          pop;

  logic [DW-1:0] mem_data [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];

  // The range is symmetric, so negation never overflows; negative zero maps to 0.
  function automatic logic signed [DW-1:0] sm_to_tc(input logic [DW-1:0] sm);
    logic signed [DW-1:0] mag;
    mag = signed'({{(DW - MAG_W){1'b0}}, sm[MAG_W-1:0]});
    return sm[DW-1] ? -mag : mag;
  endfunction

  // Shift gating depends only on registered state so out_ready never reaches the PE chain.
  assign shift_out  = (state == SHIFT) && (fcount < (AW + 1)'(FIFO_DEPTH));
  assign rst_output = (state == CLEAR);
  assign drain_busy = (state != IDLE);
  assign out_valid  = (fcount != '0);
  assign push       = shift_out;
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last   = out_valid && mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= sm_to_tc(acc_in);
      mem_last[wr_ptr] <= (cnt == CW'(N_PE - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcount     <= '0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fcount <= fcount + (AW + 1)'(1);
        2'b01:   fcount <= fcount - (AW + 1)'(1);
        default: ;
      endcase
      case (state)
        IDLE: begin
          if (drain_start) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (push) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N_PE - 1)) state <= CLEAR;
          end
        end
        // The FIFO may already empty during the clear cycle; finish without visiting FLUSH.
        CLEAR: begin
          if (pop && fcount == (AW + 1)'(1)) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end else begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && fcount == (AW + 1)'(1)) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_row_drain.sv
// Directed bench for systolic_row_drain: three instances (N_PE=4/DEPTH=4,
// N_PE=4/DEPTH=2, N_PE=1) each driven by a behavioural PE-row model.
module tb_systolic_row_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: N_PE=4, FIFO_DEPTH=4
  logic        ds_a = 1'b0, ordy_a = 1'b0, ld_a = 1'b0;
  logic        busy_a, done_a, sh_a, rsto_a, ov_a, ol_a;
  logic [15:0] acc_a, od_a;
  logic [15:0] pe_a [4];
  logic [15:0] ldv_a [4];
  int          nsh_a = 0, nrst_a = 0, ndone_a = 0, ngot_a = 0;
  logic [16:0] got_a [1024];

  // Instance B: N_PE=4, FIFO_DEPTH=2
  logic        ds_b = 1'b0, ordy_b = 1'b0, ld_b = 1'b0;
  logic        busy_b, done_b, sh_b, rsto_b, ov_b, ol_b;
  logic [15:0] acc_b, od_b;
  logic [15:0] pe_b [4];
  logic [15:0] ldv_b [4];
  int          nsh_b = 0, ndone_b = 0, ngot_b = 0;
  logic [16:0] got_b [16];

  // Instance C: N_PE=1, FIFO_DEPTH=4
  logic        ds_c = 1'b0, ordy_c = 1'b0, ld_c = 1'b0;
  logic        busy_c, done_c, sh_c, rsto_c, ov_c, ol_c;
  logic [15:0] acc_c, od_c;
  logic [15:0] pe_c [1];
  logic [15:0] ldv_c [1];
  int          nsh_c = 0, ndone_c = 0, ngot_c = 0;
  logic [16:0] got_c [16];

  systolic_row_drain #(.DATA_WIDTH_BITS(16), .INT_BITS(7), .FRAC_BITS(8), .N_PE(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .drain_start(ds_a), .drain_busy(busy_a), .drain_done(done_a),
    .shift_out(sh_a), .rst_output(rsto_a), .acc_in(acc_a), .out_valid(ov_a),
    .out_ready(ordy_a), .out_data(od_a), .out_last(ol_a));

  systolic_row_drain #(.DATA_WIDTH_BITS(16), .INT_BITS(7), .FRAC_BITS(8), .N_PE(4), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .drain_start(ds_b), .drain_busy(busy_b), .drain_done(done_b),
    .shift_out(sh_b), .rst_output(rsto_b), .acc_in(acc_b), .out_valid(ov_b),
    .out_ready(ordy_b), .out_data(od_b), .out_last(ol_b));

  systolic_row_drain #(.DATA_WIDTH_BITS(16), .INT_BITS(7), .FRAC_BITS(8), .N_PE(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .drain_start(ds_c), .drain_busy(busy_c), .drain_done(done_c),
    .shift_out(sh_c), .rst_output(rsto_c), .acc_in(acc_c), .out_valid(ov_c),
    .out_ready(ordy_c), .out_data(od_c), .out_last(ol_c));

  // PE rows: shift left on shift_out with zero entering on the right, clear on rst_output.
  assign acc_a = pe_a[0];
  assign acc_b = pe_b[0];
  assign acc_c = pe_c[0];

  always @(posedge clk) begin
    if (ld_a) for (int k = 0; k < 4; k++) pe_a[k] <= ldv_a[k];
    else if (rsto_a) for (int k = 0; k < 4; k++) pe_a[k] <= 16'h0;
    else if (sh_a) begin
      for (int k = 0; k < 3; k++) pe_a[k] <= pe_a[k+1];
      pe_a[3] <= 16'h0;
    end
    if (ld_b) for (int k = 0; k < 4; k++) pe_b[k] <= ldv_b[k];
    else if (rsto_b) for (int k = 0; k < 4; k++) pe_b[k] <= 16'h0;
    else if (sh_b) begin
      for (int k = 0; k < 3; k++) pe_b[k] <= pe_b[k+1];
      pe_b[3] <= 16'h0;
    end
    if (ld_c) pe_c[0] <= ldv_c[0];
    else if (rsto_c || sh_c) pe_c[0] <= 16'h0;
  end

  // Event monitors: count strobes and capture every accepted word with its last flag.
  always @(posedge clk) begin
    if (sh_a) nsh_a++;
    if (rsto_a) nrst_a++;
    if (done_a) ndone_a++;
    if (ov_a && ordy_a && ngot_a < 1024) begin got_a[ngot_a] = {ol_a, od_a}; ngot_a++; end
    if (sh_b) nsh_b++;
    if (done_b) ndone_b++;
    if (ov_b && ordy_b && ngot_b < 16) begin got_b[ngot_b] = {ol_b, od_b}; ngot_b++; end
    if (sh_c) nsh_c++;
    if (done_c) ndone_c++;
    if (ov_c && ordy_c && ngot_c < 16) begin got_c[ngot_c] = {ol_c, od_c}; ngot_c++; end
  end

  function automatic logic [15:0] ref_conv(input logic [15:0] sm);
    int v;
    v = int'(sm[14:0]);
    if (sm[15]) v = -v;
    return v[15:0];
  endfunction

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic start_a(input logic [15:0] w0, w1, w2, w3);
    ldv_a[0] = w0; ldv_a[1] = w1; ldv_a[2] = w2; ldv_a[3] = w3;
    ld_a = 1'b1; ds_a = 1'b1;
    @(posedge clk); #1;
    ld_a = 1'b0; ds_a = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] w0, w1, w2, w3);
    ldv_b[0] = w0; ldv_b[1] = w1; ldv_b[2] = w2; ldv_b[3] = w3;
    ld_b = 1'b1; ds_b = 1'b1;
    @(posedge clk); #1;
    ld_b = 1'b0; ds_b = 1'b0;
  endtask

  task automatic start_c(input logic [15:0] w0);
    ldv_c[0] = w0;
    ld_c = 1'b1; ds_c = 1'b1;
    @(posedge clk); #1;
    ld_c = 1'b0; ds_c = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if ({busy_a, done_a, sh_a, rsto_a, ov_a, ol_a, od_a} !== 22'h0) begin
      n_fail++; $display("FAIL reset_a: outputs=%h required 0", {busy_a, done_a, sh_a, rsto_a, ov_a, ol_a, od_a});
    end
    n_tests++;
    if ({busy_b, done_b, sh_b, rsto_b, ov_b, ol_b, od_b} !== 22'h0) begin
      n_fail++; $display("FAIL reset_b: outputs=%h required 0", {busy_b, done_b, sh_b, rsto_b, ov_b, ol_b, od_b});
    end
    n_tests++;
    if ({busy_c, done_c, sh_c, rsto_c, ov_c, ol_c, od_c} !== 22'h0) begin
      n_fail++; $display("FAIL reset_c: outputs=%h required 0", {busy_c, done_c, sh_c, rsto_c, ov_c, ol_c, od_c});
    end
    n_tests++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if ({busy_a, done_a, sh_a, rsto_a, ov_a} !== 5'h0) begin
      n_fail++; $display("FAIL idle_after_reset: outputs=%b required 00000", {busy_a, done_a, sh_a, rsto_a, ov_a});
    end
    n_tests++;
  endtask

  task automatic test_drain_basic();
    logic [16:0] exp_w [4];
    int g0, r0, d0, first, last, nsh, rc, dc;
    exp_w[0] = 17'h00180; exp_w[1] = 17'h0FE80; exp_w[2] = 17'h00000; exp_w[3] = 17'h17FFF;
    g0 = ngot_a; r0 = nrst_a; d0 = ndone_a;
    first = -1; last = -1; nsh = 0; rc = -1; dc = -1;
    ordy_a = 1'b1;
    start_a(16'h0180, 16'h8180, 16'h8000, 16'h7FFF);
    for (int c = 0; c < 40; c++) begin
      if (sh_a) begin if (first < 0) first = c; last = c; nsh++; end
      if (rsto_a && rc < 0) rc = c;
      if (done_a) begin dc = c; break; end
      @(posedge clk); #1;
    end
    if (dc < 0) begin n_fail++; $display("FAIL basic_done_timeout: done not seen, required within 40 cycles"); end
    n_tests++;
    if (nsh !== 4 || last - first !== 3) begin
      n_fail++; $display("FAIL basic_shift_run: shifts=%0d span=%0d, required 4 consecutive", nsh, last - first + 1);
    end
    n_tests++;
    if (rc !== last + 1 || dc !== rc + 1) begin
      n_fail++; $display("FAIL basic_order: last_shift=%0d rst=%0d done=%0d, required rst=last+1 done=rst+1", last, rc, dc);
    end
    n_tests++;
    repeat (3) @(posedge clk);
    #1;
    if (nrst_a - r0 !== 1 || ndone_a - d0 !== 1) begin
      n_fail++; $display("FAIL basic_pulses: rst=%0d done=%0d, required 1 and 1", nrst_a - r0, ndone_a - d0);
    end
    n_tests++;
    if (ngot_a - g0 !== 4) begin n_fail++; $display("FAIL basic_count: words=%0d required 4", ngot_a - g0); end
    n_tests++;
    for (int k = 0; k < 4; k++) begin
      if (got_a[g0 + k] !== exp_w[k]) begin
        n_fail++; $display("FAIL basic_word%0d: got {last,data}=%h required %h", k, got_a[g0 + k], exp_w[k]);
      end
      n_tests++;
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp_w [4];
    int s0, g0, d0;
    exp_w[0] = 17'h00180; exp_w[1] = 17'h0FE80; exp_w[2] = 17'h00000; exp_w[3] = 17'h17FFF;
    s0 = nsh_b; g0 = ngot_b; d0 = ndone_b;
    ordy_b = 1'b0;
    start_b(16'h0180, 16'h8180, 16'h8000, 16'h7FFF);
    repeat (8) @(posedge clk);
    #1;
    if (nsh_b - s0 !== 2) begin n_fail++; $display("FAIL bp_shift_stall: shifts=%0d required 2", nsh_b - s0); end
    n_tests++;
    if (ov_b !== 1'b1 || od_b !== 16'h0180) begin
      n_fail++; $display("FAIL bp_head: valid=%b data=%h required 1 0180", ov_b, od_b);
    end
    n_tests++;
    repeat (3) @(posedge clk);
    #1;
    if (od_b !== 16'h0180 || sh_b !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: data=%h shift=%b required 0180 0", od_b, sh_b);
    end
    n_tests++;
    ordy_b = 1'b1;
    @(posedge clk); #1;
    ordy_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (nsh_b - s0 !== 3) begin n_fail++; $display("FAIL bp_one_more: shifts=%0d required 3", nsh_b - s0); end
    n_tests++;
    ordy_b = 1'b1;
    for (int c = 0; c < 60 && !done_b; c++) begin @(posedge clk); #1; end
    if (!done_b) begin n_fail++; $display("FAIL bp_done_timeout: done not seen, required within 60 cycles"); end
    n_tests++;
    repeat (2) @(posedge clk);
    #1;
    if (nsh_b - s0 !== 4 || ndone_b - d0 !== 1) begin
      n_fail++; $display("FAIL bp_totals: shifts=%0d done=%0d required 4 1", nsh_b - s0, ndone_b - d0);
    end
    n_tests++;
    for (int k = 0; k < 4; k++) begin
      if (got_b[g0 + k] !== exp_w[k]) begin
        n_fail++; $display("FAIL bp_word%0d: got {last,data}=%h required %h", k, got_b[g0 + k], exp_w[k]);
      end
      n_tests++;
    end
  endtask

  task automatic test_ignore_start();
    logic [16:0] exp_w [4];
    int s0, g0, d0;
    exp_w[0] = 17'h00001; exp_w[1] = 17'h0FFFE; exp_w[2] = 17'h00003; exp_w[3] = 17'h1FFFC;
    s0 = nsh_a; g0 = ngot_a; d0 = ndone_a;
    ordy_a = 1'b0;
    start_a(16'h0001, 16'h8002, 16'h0003, 16'h8004);
    @(posedge clk); #1;
    ds_a = 1'b1;
    @(posedge clk); #1;
    ds_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    if (busy_a !== 1'b1 || ov_a !== 1'b1) begin
      n_fail++; $display("FAIL ign_flush_state: busy=%b valid=%b required 1 1", busy_a, ov_a);
    end
    n_tests++;
    ds_a = 1'b1;
    @(posedge clk); #1;
    ds_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (nsh_a - s0 !== 4) begin n_fail++; $display("FAIL ign_shifts_stalled: shifts=%0d required 4", nsh_a - s0); end
    n_tests++;
    ordy_a = 1'b1;
    for (int c = 0; c < 40 && !done_a; c++) begin @(posedge clk); #1; end
    repeat (6) @(posedge clk);
    #1;
    if (nsh_a - s0 !== 4 || ndone_a - d0 !== 1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL ign_totals: shifts=%0d done=%0d busy=%b required 4 1 0", nsh_a - s0, ndone_a - d0, busy_a);
    end
    n_tests++;
    for (int k = 0; k < 4; k++) begin
      if (got_a[g0 + k] !== exp_w[k]) begin
        n_fail++; $display("FAIL ign_word%0d: got {last,data}=%h required %h", k, got_a[g0 + k], exp_w[k]);
      end
      n_tests++;
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [16:0] exp_w [4];
    int s0, g0, d0;
    exp_w[0] = 17'h00010; exp_w[1] = 17'h0FFE0; exp_w[2] = 17'h00030; exp_w[3] = 17'h1FFC0;
    s0 = nsh_a; d0 = ndone_a;
    ordy_a = 1'b0;
    start_a(16'h0180, 16'h8180, 16'h8000, 16'h7FFF);
    repeat (2) @(posedge clk);
    #1;
    if (nsh_a - s0 !== 2) begin n_fail++; $display("FAIL rmid_pushed: shifts=%0d required 2", nsh_a - s0); end
    n_tests++;
    #2 rst_n = 1'b0;
    #1;
    if ({busy_a, done_a, sh_a, rsto_a, ov_a, ol_a, od_a} !== 22'h0) begin
      n_fail++; $display("FAIL rmid_async: outputs=%h required 0", {busy_a, done_a, sh_a, rsto_a, ov_a, ol_a, od_a});
    end
    n_tests++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (ov_a !== 1'b0 || busy_a !== 1'b0 || ndone_a - d0 !== 0) begin
      n_fail++; $display("FAIL rmid_after: valid=%b busy=%b done=%0d required 0 0 0", ov_a, busy_a, ndone_a - d0);
    end
    n_tests++;
    g0 = ngot_a; s0 = nsh_a;
    ordy_a = 1'b1;
    start_a(16'h0010, 16'h8020, 16'h0030, 16'h8040);
    for (int c = 0; c < 40 && !done_a; c++) begin @(posedge clk); #1; end
    if (ndone_a - d0 !== 0 || !done_a) begin
      n_fail++; $display("FAIL rmid_redrain_done: done_now=%b prior_done=%0d required 1 0", done_a, ndone_a - d0);
    end
    n_tests++;
    repeat (2) @(posedge clk);
    #1;
    if (nsh_a - s0 !== 4) begin n_fail++; $display("FAIL rmid_redrain_shifts: shifts=%0d required 4", nsh_a - s0); end
    n_tests++;
    for (int k = 0; k < 4; k++) begin
      if (got_a[g0 + k] !== exp_w[k]) begin
        n_fail++; $display("FAIL rmid_word%0d: got {last,data}=%h required %h", k, got_a[g0 + k], exp_w[k]);
      end
      n_tests++;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_w [400];
    logic [15:0] w [4];
    int s0, g0, d0;
    bit timed_out;
    s0 = nsh_a; g0 = ngot_a; d0 = ndone_a;
    timed_out = 1'b0;
    for (int d = 0; d < 100 && !timed_out; d++) begin
      for (int k = 0; k < 4; k++) begin
        w[k] = 16'($urandom);
        exp_w[d*4 + k] = {(k == 3), ref_conv(w[k])};
      end
      start_a(w[0], w[1], w[2], w[3]);
      for (int c = 0; c < 200 && !done_a; c++) begin
        ordy_a = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      if (!done_a) begin
        timed_out = 1'b1;
        n_fail++; $display("FAIL b2b_timeout: drain %0d did not finish within 200 cycles", d);
      end
      n_tests++;
    end
    ordy_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (nsh_a - s0 !== 400 || ndone_a - d0 !== 100 || ngot_a - g0 !== 400) begin
      n_fail++; $display("FAIL b2b_totals: shifts=%0d done=%0d words=%0d required 400 100 400",
                         nsh_a - s0, ndone_a - d0, ngot_a - g0);
    end
    n_tests++;
    for (int i = 0; i < 400; i++) begin
      if (got_a[g0 + i] !== exp_w[i]) begin
        n_fail++; $display("FAIL b2b_word%0d: got {last,data}=%h required %h", i, got_a[g0 + i], exp_w[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_single_pe();
    int g0, first, nsh, rc, dc;
    g0 = ngot_c; first = -1; nsh = 0; rc = -1; dc = -1;
    ordy_c = 1'b1;
    start_c(16'h8001);
    for (int c = 0; c < 30; c++) begin
      if (sh_c) begin if (first < 0) first = c; nsh++; end
      if (rsto_c && rc < 0) rc = c;
      if (done_c) begin dc = c; break; end
      @(posedge clk); #1;
    end
    if (nsh !== 1 || dc < 0) begin
      n_fail++; $display("FAIL single_shift: shifts=%0d done_cycle=%0d required 1 and seen", nsh, dc);
    end
    n_tests++;
    if (rc !== first + 1 || dc !== rc + 1) begin
      n_fail++; $display("FAIL single_order: shift=%0d rst=%0d done=%0d required consecutive", first, rc, dc);
    end
    n_tests++;
    repeat (2) @(posedge clk);
    #1;
    if (ngot_c - g0 !== 1 || got_c[g0] !== 17'h1FFFF) begin
      n_fail++; $display("FAIL single_word: count=%0d {last,data}=%h required 1 1ffff", ngot_c - g0, got_c[g0]);
    end
    n_tests++;
  endtask

  initial begin
    test_reset();
    test_drain_basic();
    test_backpressure();
    test_ignore_start();
    test_reset_mid_drain();
    test_back_to_back();
    test_single_pe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/systolic_row_drain.md
Name: systolic_row_drain

Overview:
Drain controller for one row of the systolic array's processing elements. After a compute pass it drives the row's shift_out chain to pull each PE's sign-magnitude fixed-point accumulator out of the leftmost PE, one per cycle. Each value is converted to two's complement, buffered in a small FIFO, and presented on a valid/ready stream toward the memory writer. When the row is fully drained it pulses the row's rst_output to re-arm the PEs.

Parameters:
DATA_WIDTH_BITS, 16, accumulator/output word width (1b sign + magnitude on input)
INT_BITS, 7, integer bits of the fixed-point format (pass-through; binary point preserved)
FRAC_BITS, 8, fraction bits of the fixed-point format (pass-through)
N_PE, 8, number of PEs in the row (= number of words per drain); must be >= 1
FIFO_DEPTH, 4, output buffer entries; power of two, >= 2

Ports:
clk  input  1  clock; all state on posedge
rst_n  input  1  asynchronous active-low reset
drain_start  input  1  one-cycle request to drain the row; ignored unless idle
drain_busy  output  1  high from the cycle after an accepted drain_start until drain_done
drain_done  output  1  one-cycle pulse after the last word is accepted downstream
shift_out  output  1  to every PE in the row; high = shift accumulators one place left this cycle
rst_output  output  1  to every PE in the row; one-cycle clear pulse
acc_in  input  DATA_WIDTH_BITS  accumulator of the leftmost PE, in sign-magnitude
out_valid  output  1  stream valid
out_ready  input  1  stream ready
out_data  output  DATA_WIDTH_BITS  drained word, two's complement, same binary point
out_last  output  1  qualifies the N_PE-th word of a drain

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; FIFO empty; counter 0.
  - All outputs are 0: drain_busy, drain_done, shift_out, rst_output, out_valid, out_data, out_last.
  - Reset mid-drain aborts the drain with no done pulse. PE contents are then undefined, and software re-runs the pass.
- FSM states: IDLE, SHIFT, CLEAR, FLUSH.
- IDLE:
  - drain_start=1 -> SHIFT; counter cleared.
  - drain_start in any other state is ignored.
- SHIFT:
  - shift_out = (count < FIFO_DEPTH). It is derived only from registered state, with no combinational path from out_ready.
  - In every cycle shift_out=1, acc_in (the value before the shift edge) is converted and pushed into the FIFO. out_last for that entry = (counter == N_PE-1). Counter increments.
  - After the N_PE-th push -> CLEAR.
  - FIFO full: shift_out=0 and no push. PEs hold their accumulators.
- CLEAR:
  - rst_output=1 for exactly one cycle, shift_out=0 -> FLUSH.
- FLUSH:
  - Wait until the FIFO is empty. The cycle after the last entry is popped, drain_done=1 for one cycle -> IDLE.
  - drain_busy falls in the same cycle drain_done is asserted.
- Push timing: the PE chain shifts a zero into the rightmost PE (integration ties accumulator_shift of the last PE to 0). So the words appear in order PE0, PE1, ..., PE(N_PE-1), and exactly N_PE shift_out cycles occur per drain.
- FIFO:
  - Registered storage; out_data and out_last come from the head entry.
  - out_valid = (count != 0). Pop when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, ordering preserved. A push is never accepted at count == FIFO_DEPTH, even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Conversion, with s = acc_in[MSB] and m = acc_in[MSB-1:0]:
  - s=0: out = {1'b0, m}.
  - s=1: out = two's-complement negation of {1'b0, m}, computed modulo 2^DATA_WIDTH_BITS.
  - Negative zero (s=1, m=0) yields 0.
  - No saturation is needed; the range is symmetric.
- drain_busy = (state != IDLE).

Test Plan:
1. N_PE=4, FIFO_DEPTH=4, out_ready=1, PE words 0x0180, 0x8180, 0x8000, 0x7FFF; pulse drain_start:
   - shift_out high 4 consecutive cycles.
   - out_data sequence 0x0180, 0xFE80, 0x0000, 0x7FFF, with out_last only on the 4th.
   - rst_output pulses once after the 4th shift, then drain_done pulses once.
2. Backpressure, N_PE=4, FIFO_DEPTH=2, out_ready=0:
   - shift_out high exactly 2 cycles, then low; out_valid held with out_data 0x0180 stable.
   - Raise out_ready for 1 cycle -> exactly one further shift_out cycle.
   - Full drain completes with all 4 words in order.
3. drain_start pulsed again during SHIFT and during FLUSH -> ignored: exactly N_PE shifts and a single drain_done.
4. rst_n asserted low mid-SHIFT after 2 words:
   - All outputs go to 0 asynchronously; out_valid=0 and FIFO empty after release; no drain_done.
   - A new drain_start works normally.
5. Random out_ready (50%) over 100 back-to-back drains with random sign-magnitude words:
   - The output stream matches the reference conversion in order.
   - out_last appears every N_PE words; count of shift_out cycles = 100*N_PE.
6. N_PE=1, 0x8001 -> single word 0xFFFF with out_last=1, then rst_output, then drain_done.
